// File: rtl/bus_interface_arbiter.sv
// N-channel arbiter onto the single core bus: fixed-priority or round-robin grant,
// per-transaction watchdog with error response, and saturating per-channel completion counters.
module bus_interface_arbiter #(
  parameter int CHANNELS       = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [CHANNELS-1:0]            i_ch_vaild,
  input  logic [CHANNELS-1:0]            i_ch_write_enable,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] i_ch_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_ch_data_write,
  output logic [CHANNELS-1:0]            o_ch_ready,
  output logic [CHANNELS-1:0]            o_ch_error,
  output logic [DATA_WIDTH-1:0]          o_ch_data_read,
  output logic [CHANNELS*16-1:0]         o_grant_count,
  output logic                           o_bus_vaild,
  input  logic                           i_bus_ready,
  input  logic                           i_bus_busy,
  output logic                           o_bus_write_enable,
  output logic [ADDR_WIDTH-1:0]          o_bus_address,
  input  logic [DATA_WIDTH-1:0]          i_bus_data_read,
  output logic [DATA_WIDTH-1:0]          o_bus_data_write
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                state, state_next;
  logic [GW-1:0]         grant, pointer, base, sel_idx, pointer_next;
  logic [GW:0]           sum, inc;
  logic [CHANNELS-1:0]   rotated;
  logic                  sel_found, sel_write, timeout_hit;
  logic [ADDR_WIDTH-1:0] sel_addr, addr_q;
  logic [DATA_WIDTH-1:0] sel_wdata, wdata_q, rdata_q;
  logic                  we_q, err_q;
  logic [TW-1:0]         tcount;
  logic [15:0]           counts [CHANNELS];

  // Rotate requests so the search starts at the pointer; the downward loop leaves the lowest hit.
  always_comb begin
    base      = (ARB_MODE == 1) ? pointer : '0;
    rotated   = CHANNELS'({i_ch_vaild, i_ch_vaild} >> base);
    sum       = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rotated[i]) sum = {1'b0, base} + (GW+1)'(i);
    end
    if (sum >= (GW+1)'(CHANNELS)) sum = sum - (GW+1)'(CHANNELS);
    sel_idx      = sum[GW-1:0];
    sel_found    = |i_ch_vaild;
    inc          = {1'b0, sel_idx} + (GW+1)'(1);
    pointer_next = (inc == (GW+1)'(CHANNELS)) ? '0 : inc[GW-1:0];
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == GW'(k)) begin
        sel_write = i_ch_write_enable[k];
        sel_addr  = i_ch_address[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_ch_data_write[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready has priority over the watchdog when both land in the same cycle.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:    if (sel_found && !i_bus_busy) state_next = ACCESS;
      ACCESS: begin
        if (i_bus_ready) begin
          state_next = RESPOND;
        end else if (TIMEOUT_CYCLES > 0 && tcount == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      grant   <= '0;
      pointer <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcount  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (state_next == ACCESS) begin
            grant   <= sel_idx;
            addr_q  <= sel_addr;
            we_q    <= sel_write;
            wdata_q <= sel_wdata;
            tcount  <= '0;
            err_q   <= 1'b0;
            if (ARB_MODE == 1) pointer <= pointer_next;
          end
        end
        ACCESS: begin
          if (i_bus_ready) begin
            if (!we_q) rdata_q <= i_bus_data_read;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < CHANNELS; k++) counts[k] <= '0;
    end else if (state == RESPOND) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (grant == GW'(k) && counts[k] != 16'hFFFF) counts[k] <= counts[k] + 16'd1;
      end
    end
  end

  always_comb begin
    o_ch_ready    = '0;
    o_ch_error    = '0;
    o_grant_count = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      o_grant_count[k*16 +: 16] = counts[k];
      if (state == RESPOND && grant == GW'(k)) begin
        o_ch_ready[k] = 1'b1;
        o_ch_error[k] = err_q;
      end
    end
  end

  assign o_bus_vaild        = (state == ACCESS);
  assign o_bus_write_enable = we_q;
  assign o_bus_address      = addr_q;
  assign o_bus_data_write   = wdata_q;
  assign o_ch_data_read     = rdata_q;

endmodule

// File: doc/bus_interface_arbiter.md
Name: bus_interface_arbiter

Overview:
- Parametrised successor to the fixed two-channel (code/data) bus interface unit: arbitrates N requester channels onto the single external core bus.
- Sits between the fetch and execute/memory units and the core bus pins.
- Adds selectable fixed-priority or round-robin arbitration, configurable address and data widths, a per-transaction watchdog timeout with an error response, and a per-channel transaction counter.

Parameters:
- CHANNELS, 2, number of requester channels (1..8); channel 0 is the code channel.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 16, cycles in ACCESS without i_bus_ready before aborting; 0 disables the timeout.

Ports:
- i_clock  input  1  core clock.
- i_reset  input  1  asynchronous active-low reset.
- i_ch_vaild  input  CHANNELS  per-channel request valid.
- i_ch_write_enable  input  CHANNELS  per-channel write flag.
- i_ch_address  input  CHANNELS*ADDR_WIDTH  packed addresses; channel k occupies [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_ch_data_write  input  CHANNELS*DATA_WIDTH  packed write data.
- o_ch_ready  output  CHANNELS  one-hot completion pulse.
- o_ch_error  output  CHANNELS  one-hot timeout pulse, coincident with o_ch_ready.
- o_ch_data_read  output  DATA_WIDTH  read data, shared by all channels, valid when any o_ch_ready is high.
- o_grant_count  output  CHANNELS*16  per-channel completed-transaction counters.
- o_bus_vaild  output  1  bus request.
- i_bus_ready  input  1  bus completion.
- i_bus_busy  input  1  bus is unavailable for a new request.
- o_bus_write_enable  output  1  bus write.
- o_bus_address  output  ADDR_WIDTH  bus address.
- i_bus_data_read  input  DATA_WIDTH  bus read data.
- o_bus_data_write  output  DATA_WIDTH  bus write data.

Behaviour:
- Clock and reset: one clock, i_clock; i_reset is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counters 0. Assertion mid-transaction aborts immediately; no ready or error pulse is issued.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - If any i_ch_vaild is set and i_bus_busy=0, select a grant, latch that channel's address, write_enable and write data, and go to ACCESS.
  - While i_bus_busy=1, stay in IDLE.
  - i_bus_busy is sampled only in IDLE.
- ACCESS:
  - o_bus_vaild=1; bus outputs are driven from the latched registers and stay stable.
  - When i_bus_ready=1: capture i_bus_data_read (reads only; writes leave the data register unchanged) and go to RESPOND.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES, go to RESPOND with the error flag set and the data register zeroed.
- RESPOND:
  - o_bus_vaild=0; o_ch_ready[grant]=1 for exactly one cycle; o_ch_error[grant]=1 if the transaction timed out.
  - Increment o_grant_count[grant], saturating at 16'hFFFF.
  - Return to IDLE.
- Latency: request seen in cycle 0 → o_bus_vaild in cycle 1 → if ready in cycle 1, o_ch_ready in cycle 2 → next grant decided in cycle 3. Minimum 3 cycles per transaction; no back-to-back overlap.
- Fixed priority: the lowest-indexed valid channel wins.
- Round-robin:
  - Search starts at pointer p and wraps modulo CHANNELS.
  - After granting k, p becomes (k+1) mod CHANNELS.
  - The pointer is unchanged when nothing is granted.
- Requester contract: a channel holds valid and payload until its ready pulse. If valid drops during ACCESS, the transaction still completes and ready is still pulsed; the bus is never glitched.
- i_bus_ready outside ACCESS is ignored.
- CHANNELS=1 degenerates to a pass-through with the same timing.
- Timeout counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to ACCESS.
  - Ready arriving in the same cycle the count reaches TIMEOUT_CYCLES wins: normal completion, no error.

Test Plan:
- Single read: CHANNELS=2; ch1 read at 0x0000_1000, bus ready after 2 cycles with 0xDEAD_BEEF → o_bus_address=0x0000_1000 while o_bus_vaild; o_ch_ready=2'b10 for one cycle; o_ch_data_read=0xDEAD_BEEF; o_grant_count[1]=1.
- Fixed priority: ARB_MODE=0; ch0 and ch1 both valid continuously → grant sequence 0,0,0…; ch1 is not served until ch0 deasserts.
- Round-robin: ARB_MODE=1, CHANNELS=4; all valid continuously → grant order 0,1,2,3,0; each counter reads 1 after the first four completions.
- Busy gating: i_bus_busy=1 for 5 cycles with ch0 valid → o_bus_vaild stays 0; asserted the cycle after busy drops. Busy asserted during ACCESS → no effect.
- Timeout: TIMEOUT_CYCLES=4, bus never ready → after 4 ACCESS cycles, o_ch_ready[0]=o_ch_error[0]=1 and o_ch_data_read=0. Ready arriving on cycle 4 instead → completes with no error.
- Reset mid-ACCESS: assert i_reset=0 asynchronously → o_bus_vaild drops with no clock edge; after release, no stale ready pulse; pointer and counters read 0.
